// File: rtl/sys_regfile.sv
// Wishbone system register block: board ID constants, 64-bit uptime, access statistics,
// byte-enabled scratchpad, registered status inputs and strobed control outputs.
module sys_regfile #(
  parameter logic [31:0] BOARD_ID  = 32'h0,
  parameter logic [31:0] REV_MAJ   = 32'h0,
  parameter logic [31:0] REV_MIN   = 32'h0,
  parameter logic [31:0] REV_RCS   = 32'h0,
  parameter int          N_SCRATCH = 4,
  parameter int          N_IN      = 8,
  parameter int          N_OUT     = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [31:0]           wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  input  logic [32*N_IN-1:0]    regin,
  output logic [32*N_OUT-1:0]   regout,
  output logic [N_OUT-1:0]      regout_stb
);

  logic [5:0]  word;
  logic        req, hit, writable, valid;
  logic [31:0] rd_data, wr_mask;
  logic [63:0] uptime;
  logic [31:0] hi_snap, wr_count, err_count;
  logic [31:0] scratch [N_SCRATCH];
  logic [31:0] regin_q [N_IN];
  logic        unused_adr;

  assign word       = wb_adr_i[7:2];
  assign unused_adr = ^{wb_adr_i[31:8], wb_adr_i[1:0]};
  // The response register doubles as the busy flag: a strobe held through the ack is not a new request.
  assign req        = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign wr_mask    = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign valid      = hit & (~wb_we_i | writable);

  // NOTE: every variable gets a default before the case; a path that leaves one unassigned infers a latch.
  always_comb begin
    hit      = 1'b0;
    writable = 1'b0;
    rd_data  = '0;
    case (word)
      6'h00: begin hit = 1'b1; rd_data = BOARD_ID;        end
      6'h01: begin hit = 1'b1; rd_data = REV_MAJ;         end
      6'h02: begin hit = 1'b1; rd_data = REV_MIN;         end
      6'h03: begin hit = 1'b1; rd_data = REV_RCS;         end
      6'h04: begin hit = 1'b1; rd_data = uptime[31:0];    end
      6'h05: begin hit = 1'b1; rd_data = hi_snap;         end
      6'h06: begin hit = 1'b1; rd_data = wr_count;        end
      6'h07: begin hit = 1'b1; writable = 1'b1; rd_data = err_count; end
      default: ;
    endcase
    for (int i = 0; i < N_SCRATCH; i++) begin
      if (word == 6'(8 + i)) begin
        hit      = 1'b1;
        writable = 1'b1;
        rd_data  = scratch[i];
      end
    end
    for (int i = 0; i < N_IN; i++) begin
      if (word == 6'(16 + i)) begin
        hit     = 1'b1;
        rd_data = regin_q[i];
      end
    end
    for (int i = 0; i < N_OUT; i++) begin
      if (word == 6'(32 + i)) begin
        hit      = 1'b1;
        writable = 1'b1;
        rd_data  = regout[32*i +: 32];
      end
    end
  end

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_ack_o   <= 1'b0;
      wb_err_o   <= 1'b0;
      wb_dat_o   <= '0;
      regout     <= '0;
      regout_stb <= '0;
      uptime     <= '0;
      hi_snap    <= '0;
      wr_count   <= '0;
      err_count  <= '0;
      // NOTE: the scratchpad must clear on reset, so it is built from flops rather than a RAM macro.
      for (int i = 0; i < N_SCRATCH; i++) scratch[i] <= '0;
      for (int i = 0; i < N_IN; i++)      regin_q[i] <= '0;
    end else begin
      uptime     <= uptime + 64'd1;
      for (int i = 0; i < N_IN; i++) regin_q[i] <= regin[32*i +: 32];
      wb_ack_o   <= 1'b0;
      wb_err_o   <= 1'b0;
      wb_dat_o   <= '0;
      regout_stb <= '0;
      if (req) begin
        if (!valid) begin
          wb_err_o <= 1'b1;
          if (err_count != '1) err_count <= err_count + 32'd1;
        end else begin
          wb_ack_o <= 1'b1;
          if (wb_we_i) begin
            wr_count <= wr_count + 32'd1;
            if (word == 6'h07) err_count <= '0;
            for (int i = 0; i < N_SCRATCH; i++) begin
              if (word == 6'(8 + i))
                scratch[i] <= (scratch[i] & ~wr_mask) | (wb_dat_i & wr_mask);
            end
            for (int i = 0; i < N_OUT; i++) begin
              if (word == 6'(32 + i)) begin
                regout[32*i +: 32] <= (regout[32*i +: 32] & ~wr_mask) | (wb_dat_i & wr_mask);
                regout_stb[i]      <= 1'b1;
              end
            end
          end else begin
            wb_dat_o <= rd_data;
            if (word == 6'h04) hi_snap <= uptime[63:32];
          end
        end
      end
    end
  end

endmodule
